// File: rtl/mem_access_stage.sv
// Memory access stage: drives a req/gnt/rvalid data port, aligns load data and retires one result per instruction.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_access_stage #(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      exValid,
    input  logic [ADDR_WIDTH-1:0]     exAluResult,
    input  logic [31:0]               exStoreData,
    input  logic                      exMemRead,
    input  logic                      exMemWrite,
    input  logic [2:0]                exFunct3,
    input  logic [REG_ADDR_WIDTH-1:0] exRd,
    input  logic                      exRegWrite,
    output logic                      memStall,
    output logic                      dmemReq,
    output logic                      dmemWe,
    output logic [ADDR_WIDTH-1:0]     dmemAddr,
    output logic [3:0]                dmemBe,
    output logic [31:0]               dmemWdata,
    input  logic                      dmemGnt,
    input  logic                      dmemRvalid,
    input  logic [31:0]               dmemRdata,
    output logic                      wbValid,
    output logic [31:0]               wbResult,
    output logic [REG_ADDR_WIDTH-1:0] wbRd,
    output logic                      wbRegWrite,
    output logic                      misalignTrap
);

    // state  | meaning
    // IDLE   | accepting EX; ALU results retire next cycle
    // REQ    | memory request presented, waiting for dmemGnt
    // WAIT_R | load granted, waiting for dmemRvalid
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

    state_t state, state_nxt;

    logic                      is_mem;
    logic                      misalign;
    logic [1:0]                off;
    logic [3:0]                be;
    logic [31:0]               wdata;
    logic [31:0]               shifted;
    logic [31:0]               load_data;

    logic                      we_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [3:0]                be_q;
    logic [31:0]               wdata_q;
    logic [2:0]                funct3_q;
    logic [1:0]                off_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      regwrite_q;

    assign is_mem = exMemRead | exMemWrite;

    // funct3[1:0]: 00 byte, 01 half, anything else is handled as a word access
    always_comb begin
        off   = 2'b00;
        be    = 4'b1111;
        wdata = exStoreData;
        case (exFunct3[1:0])
            2'b00: begin
                off   = exAluResult[1:0];
                be    = 4'b0001 << exAluResult[1:0];
                wdata = {4{exStoreData[7:0]}};
            end
            2'b01: begin
                off   = {exAluResult[1], 1'b0};
                be    = exAluResult[1] ? 4'b1100 : 4'b0011;
                wdata = {2{exStoreData[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign = (exFunct3[1:0] == 2'b01) ? exAluResult[0]
                    : ((exFunct3[1:0] != 2'b00) && (exAluResult[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign shifted = dmemRdata >> {off_q, 3'b000};

    always_comb begin
        load_data = shifted;
        case (funct3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (exValid && is_mem && !misalign) state_nxt = REQ;
            REQ:     if (dmemGnt) state_nxt = we_q ? IDLE : WAIT_R;
            WAIT_R:  if (dmemRvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign memStall  = (state != IDLE);
    assign dmemReq   = (state == REQ);
    assign dmemWe    = dmemReq & we_q;
    assign dmemAddr  = dmemReq ? addr_q  : '0;
    assign dmemBe    = dmemReq ? be_q    : 4'b0000;
    assign dmemWdata = (dmemReq && we_q) ? wdata_q : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= 32'h0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
        end else if (state == IDLE && exValid && is_mem) begin
            we_q       <= exMemWrite;
            addr_q     <= {exAluResult[ADDR_WIDTH-1:2], 2'b00};
            be_q       <= be;
            wdata_q    <= wdata;
            funct3_q   <= exFunct3;
            off_q      <= off;
            rd_q       <= exRd;
            regwrite_q <= exRegWrite;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wbValid      <= 1'b0;
            wbResult     <= 32'h0;
            wbRd         <= '0;
            wbRegWrite   <= 1'b0;
            misalignTrap <= 1'b0;
        end else begin
            wbValid      <= 1'b0;
            misalignTrap <= 1'b0;
            case (state)
                IDLE: if (exValid) begin
                    if (!is_mem) begin
                        wbValid    <= 1'b1;
                        wbResult   <= 32'(exAluResult);
                        wbRd       <= exRd;
                        wbRegWrite <= exRegWrite && (exRd != '0);
                    end else if (misalign) begin
                        wbValid      <= 1'b1;
                        wbResult     <= 32'h0;
                        wbRd         <= exRd;
                        wbRegWrite   <= 1'b0;
                        misalignTrap <= 1'b1;
                    end
                end
                REQ: if (dmemGnt && we_q) begin
                    wbValid    <= 1'b1;
                    wbResult   <= 32'h0;
                    wbRd       <= rd_q;
                    wbRegWrite <= 1'b0;
                end
                WAIT_R: if (dmemRvalid) begin
                    wbValid    <= 1'b1;
                    wbResult   <= load_data;
                    wbRd       <= rd_q;
                    wbRegWrite <= regwrite_q && (rd_q != '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed ALU, store and load vectors with hand-computed results.
// Build with MISALIGN_TRAP_EN defined to exercise the trap path.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        exValid;
    logic [31:0] exAluResult;
    logic [31:0] exStoreData;
    logic        exMemRead;
    logic        exMemWrite;
    logic [2:0]  exFunct3;
    logic [4:0]  exRd;
    logic        exRegWrite;
    logic        memStall;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [3:0]  dmemBe;
    logic [31:0] dmemWdata;
    logic        dmemGnt;
    logic        dmemRvalid;
    logic [31:0] dmemRdata;
    logic        wbValid;
    logic [31:0] wbResult;
    logic [4:0]  wbRd;
    logic        wbRegWrite;
    logic        misalignTrap;

    mem_access_stage #(.ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .exValid(exValid), .exAluResult(exAluResult), .exStoreData(exStoreData),
        .exMemRead(exMemRead), .exMemWrite(exMemWrite), .exFunct3(exFunct3),
        .exRd(exRd), .exRegWrite(exRegWrite), .memStall(memStall),
        .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemBe(dmemBe),
        .dmemWdata(dmemWdata), .dmemGnt(dmemGnt), .dmemRvalid(dmemRvalid),
        .dmemRdata(dmemRdata), .wbValid(wbValid), .wbResult(wbResult), .wbRd(wbRd),
        .wbRegWrite(wbRegWrite), .misalignTrap(misalignTrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        rw;
        logic        trap;
        logic        care;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_wb(input logic [31:0] res, input logic [4:0] rd, input logic rw,
                             input logic trap, input logic care);
        exp_t e;
        e.result = res; e.rd = rd; e.rw = rw; e.trap = trap; e.care = care;
        sb.push_back(e);
    endtask

    // Monitor: every wbValid pulse must match the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && wbValid) begin
                if (sb.size() == 0) begin
                    chk("spurious_wbValid", {31'h0, wbValid}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    if (e.care) begin
                        chk("wbResult", wbResult, e.result);
                        chk("wbRd", {27'h0, wbRd}, {27'h0, e.rd});
                    end
                    chk("wbRegWrite", {31'h0, wbRegWrite}, {31'h0, e.rw});
                    chk("misalignTrap", {31'h0, misalignTrap}, {31'h0, e.trap});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [31:0] alu, input logic [31:0] sdata, input logic [4:0] rd,
                         input logic rw, input logic [2:0] f3, input logic mr, input logic mw);
        @(posedge clk);
        #1;
        exValid = 1'b1; exAluResult = alu; exStoreData = sdata; exRd = rd;
        exRegWrite = rw; exFunct3 = f3; exMemRead = mr; exMemWrite = mw;
        @(posedge clk);
        #1;
        exValid = 1'b0; exMemRead = 1'b0; exMemWrite = 1'b0;
    endtask

    task automatic alu_op(input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                          input logic exp_rw);
        expect_wb(alu, rd, exp_rw, 1'b0, 1'b1);
        issue(alu, 32'h0, rd, rw, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        chk("alu_wbValid_latency1", {31'h0, wbValid}, 32'h1);
        chk("alu_memStall", {31'h0, memStall}, 32'h0);
    endtask

    task automatic mem_op(input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                          input logic rw, input logic [2:0] f3, input logic st,
                          input int gdly, input int rdly, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_res,
                          input logic exp_rw);
        expect_wb(exp_res, rd, exp_rw, 1'b0, !st);
        issue(addr, sdata, rd, rw, f3, !st, st);
        for (int i = 0; i <= gdly; i++) begin
            @(negedge clk);
            chk("req_dmemReq", {31'h0, dmemReq}, 32'h1);
            chk("req_dmemWe", {31'h0, dmemWe}, {31'h0, st});
            chk("req_dmemAddr", dmemAddr, exp_addr);
            chk("req_dmemBe", {28'h0, dmemBe}, {28'h0, exp_be});
            if (st) chk("req_dmemWdata", dmemWdata, exp_wd);
            chk("req_memStall", {31'h0, memStall}, 32'h1);
            chk("req_no_wbValid", {31'h0, wbValid}, 32'h0);
            if (i == gdly) dmemGnt = 1'b1;
        end
        @(posedge clk);
        #1;
        dmemGnt = 1'b0;
        if (!st) begin
            for (int j = 0; j <= rdly; j++) begin
                @(negedge clk);
                chk("waitr_memStall", {31'h0, memStall}, 32'h1);
                chk("waitr_dmemReq", {31'h0, dmemReq}, 32'h0);
                chk("waitr_no_wbValid", {31'h0, wbValid}, 32'h0);
                if (j == rdly) begin
                    dmemRvalid = 1'b1;
                    dmemRdata  = rdata;
                end
            end
            @(posedge clk);
            #1;
            dmemRvalid = 1'b0;
            dmemRdata  = 32'h5A5A_5A5A;
        end
        @(negedge clk);
        chk("mem_wbValid_after_done", {31'h0, wbValid}, 32'h1);
        chk("mem_memStall_released", {31'h0, memStall}, 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_memStall"}, {31'h0, memStall}, 32'h0);
        chk({tag, "_dmemReq"}, {31'h0, dmemReq}, 32'h0);
        chk({tag, "_dmemWe"}, {31'h0, dmemWe}, 32'h0);
        chk({tag, "_dmemAddr"}, dmemAddr, 32'h0);
        chk({tag, "_dmemBe"}, {28'h0, dmemBe}, 32'h0);
        chk({tag, "_dmemWdata"}, dmemWdata, 32'h0);
        chk({tag, "_wbValid"}, {31'h0, wbValid}, 32'h0);
        chk({tag, "_wbResult"}, wbResult, 32'h0);
        chk({tag, "_wbRd"}, {27'h0, wbRd}, 32'h0);
        chk({tag, "_wbRegWrite"}, {31'h0, wbRegWrite}, 32'h0);
        chk({tag, "_misalignTrap"}, {31'h0, misalignTrap}, 32'h0);
    endtask

    initial begin
        reset = 1'b1; exValid = 1'b0; exAluResult = 32'h0; exStoreData = 32'h0;
        exMemRead = 1'b0; exMemWrite = 1'b0; exFunct3 = 3'b000; exRd = 5'd0;
        exRegWrite = 1'b0; dmemGnt = 1'b0; dmemRvalid = 1'b0; dmemRdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // ALU pass-through
        alu_op(32'h0000_1234, 5'd5, 1'b1, 1'b1);
        alu_op(32'hFFFF_0001, 5'd0, 1'b1, 1'b0);
        alu_op(32'h8000_0000, 5'd9, 1'b0, 1'b0);

        // stores: addr, data, rd, rw, f3, st, gdly, rdly, rdata, exp_addr, exp_be, exp_wdata
        mem_op(32'h0000_0103, 32'h1234_56AB, 5'd0, 1'b0, 3'b000, 1'b1, 3, 0, 32'h0,
               32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 32'h0, 1'b0);
        mem_op(32'h0000_0102, 32'h0000_BEEF, 5'd3, 1'b0, 3'b001, 1'b1, 0, 0, 32'h0,
               32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0);
        mem_op(32'h0000_0200, 32'hDEAD_BEEF, 5'd0, 1'b0, 3'b010, 1'b1, 1, 0, 32'h0,
               32'h0000_0200, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);

        // loads
        mem_op(32'h0000_0102, 32'h0, 5'd6, 1'b1, 3'b000, 1'b0, 0, 0, 32'h0080_0000,
               32'h0000_0100, 4'b0100, 32'h0, 32'hFFFF_FF80, 1'b1);
        mem_op(32'h0000_0102, 32'h0, 5'd6, 1'b1, 3'b100, 1'b0, 0, 0, 32'h0080_0000,
               32'h0000_0100, 4'b0100, 32'h0, 32'h0000_0080, 1'b1);
        mem_op(32'h0000_0102, 32'h0, 5'd8, 1'b1, 3'b101, 1'b0, 2, 1, 32'hBEEF_0000,
               32'h0000_0100, 4'b1100, 32'h0, 32'h0000_BEEF, 1'b1);
        mem_op(32'h0000_0100, 32'h0, 5'd10, 1'b1, 3'b001, 1'b0, 0, 0, 32'h0000_8001,
               32'h0000_0100, 4'b0011, 32'h0, 32'hFFFF_8001, 1'b1);
        mem_op(32'h0000_0104, 32'h0, 5'd0, 1'b1, 3'b010, 1'b0, 0, 4, 32'hCAFE_F00D,
               32'h0000_0104, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0);

        // stray gnt/rvalid while idle must not retire anything or start a request
        @(negedge clk);
        dmemGnt = 1'b1; dmemRvalid = 1'b1; dmemRdata = 32'h1111_2222;
        @(posedge clk);
        #1;
        dmemGnt = 1'b0; dmemRvalid = 1'b0;
        @(negedge clk);
        chk("idle_stray_memStall", {31'h0, memStall}, 32'h0);
        chk("idle_stray_wbValid", {31'h0, wbValid}, 32'h0);

        // reset while waiting for read data abandons the load
        issue(32'h0000_0300, 32'h0, 5'd4, 1'b1, 3'b010, 1'b1, 1'b0);
        @(negedge clk);
        dmemGnt = 1'b1;
        @(posedge clk);
        #1;
        dmemGnt = 1'b0;
        @(negedge clk);
        chk("waitr_before_reset", {31'h0, memStall}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        dmemRvalid = 1'b1; dmemRdata = 32'h3333_4444;
        @(posedge clk);
        #1;
        dmemRvalid = 1'b0;
        @(negedge clk);
        chk("post_reset_rvalid_ignored", {31'h0, wbValid}, 32'h0);

        // word load at a half-word offset
`ifdef MISALIGN_TRAP_EN
        expect_wb(32'h0, 5'd7, 1'b0, 1'b1, 1'b0);
        issue(32'h0000_0102, 32'h0, 5'd7, 1'b1, 3'b010, 1'b1, 1'b0);
        @(negedge clk);
        chk("trap_no_dmemReq", {31'h0, dmemReq}, 32'h0);
        chk("trap_memStall", {31'h0, memStall}, 32'h0);
        chk("trap_wbValid", {31'h0, wbValid}, 32'h1);
        chk("trap_pulse", {31'h0, misalignTrap}, 32'h1);
        @(negedge clk);
        chk("trap_pulse_ends", {31'h0, misalignTrap}, 32'h0);
`else
        mem_op(32'h0000_0102, 32'h0, 5'd7, 1'b1, 3'b010, 1'b0, 0, 0, 32'h1234_5678,
               32'h0000_0100, 4'b1111, 32'h0, 32'h1234_5678, 1'b1);
        chk("notrap_misalignTrap", {31'h0, misalignTrap}, 32'h0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory stage directly downstream of the execute ALU. It consumes the ALU result as the load/store effective address (or as a pass-through result for non-memory ops), together with store data, funct3 and destination register. It drives a req/gnt/rvalid data-memory port, aligns and sign/zero-extends load data, and presents one retired result per instruction to writeback. It stalls the upstream pipeline while a memory transaction is outstanding.

Parameters:
ADDR_WIDTH, 32, width of dmemAddr and exAluResult.
REG_ADDR_WIDTH, 5, width of register specifiers.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
exValid  in  1  EX presents an instruction this cycle
exAluResult  in  ADDR_WIDTH  ALU output; address for loads/stores, result otherwise
exStoreData  in  32  rs2 value for stores
exMemRead  in  1  instruction is a load
exMemWrite  in  1  instruction is a store (never both with exMemRead)
exFunct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
exRd  in  REG_ADDR_WIDTH  destination register
exRegWrite  in  1  instruction writes rd
memStall  out  1  upstream must hold EX outputs stable
dmemReq  out  1  memory request valid
dmemWe  out  1  1 = write
dmemAddr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 00)
dmemBe  out  4  byte enables
dmemWdata  out  32  lane-replicated store data
dmemGnt  in  1  request accepted this cycle
dmemRvalid  in  1  read data valid
dmemRdata  in  32  read data word
wbValid  out  1  retired instruction presented to WB (one-cycle pulse per instruction)
wbResult  out  32  value to write
wbRd  out  REG_ADDR_WIDTH  destination register
wbRegWrite  out  1  write enable to register file
misalignTrap  out  1  misaligned-access pulse (see Optional Feature)

Behaviour:
- Reset: state IDLE; all outputs 0. Reset mid-transaction abandons it; rvalid/gnt arriving after reset while in IDLE are ignored.
- FSM states: IDLE, REQ, WAIT_R. memStall = (state != IDLE), registered-state decode.
- IDLE, exValid, no mem op: next cycle wbValid=1, wbResult=exAluResult, wbRd/wbRegWrite from inputs. Latency 1.
- IDLE, exValid, mem op: capture addr, funct3, rd, regWrite, store data; go REQ.
- REQ: dmemReq=1; dmemAddr/We/Be/Wdata held constant until dmemGnt. On gnt: store -> IDLE and wbValid next cycle with wbRegWrite=0; load -> WAIT_R.
- WAIT_R: dmemReq=0; wait any number of cycles for dmemRvalid; on rvalid -> IDLE, wbValid next cycle with extracted data.
- dmemGnt ignored outside REQ; dmemRvalid ignored outside WAIT_R; rvalid never arrives in the gnt cycle.
- Byte enables: B -> 0001<<addr[1:0], wdata = byte replicated x4; H -> addr[1]?1100:0011, wdata = half replicated x2; W -> 1111, wdata as-is. Loads drive the same Be.
- Load extraction: shift dmemRdata right by 8*addr[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend. Unsupported funct3 (011,110,111) treated as W.
- wbRegWrite forced 0 when rd == 0. wbValid is 0 in all cycles not listed above.
- Minimum latencies: store 2 cycles, load 3 cycles (gnt first REQ cycle, rvalid next).

Optional Feature:
MISALIGN_TRAP_EN. Defined: in IDLE, H/HU with addr[0]=1 or W with addr[1:0]!=0 issues no request; next cycle wbValid=1, wbRegWrite=0, misalignTrap=1 for that cycle only. Undefined: misalignTrap tied 0; low address bits not needed for the access are ignored (H uses addr[1] only, W forces 00) and the access proceeds.

Test Plan:
- ADD result 0x0000_1234, rd=5 -> one cycle later wbValid=1, wbResult=0x1234, wbRd=5, wbRegWrite=1, memStall never 1.
- SB addr 0x103, data 0xAB -> dmemAddr=0x100, Be=1000, Wdata=0xABABABAB; gnt delayed 3 cycles, request held stable; wbValid with wbRegWrite=0 the cycle after gnt.
- LB addr 0x102, rdata 0x0080_0000 -> wbResult=0xFFFF_FF80; LBU same -> 0x0000_0080; LHU addr 0x102, rdata 0xBEEF_0000 -> 0x0000_BEEF.
- LW rd=0, rvalid 5 cycles after gnt -> memStall high throughout, wbRegWrite=0, spurious rvalid in IDLE ignored.
- Reset asserted in WAIT_R -> next cycle all outputs 0, IDLE; later rvalid produces no wbValid.
- LW addr 0x102: with MISALIGN_TRAP_EN -> no dmemReq, misalignTrap=1, wbRegWrite=0; without -> dmemAddr=0x100, normal load.
